// File: rtl/module_scan_counter_if.sv
// module_scan_counter_if: control and status bundle of the scan counter.
interface module_scan_counter_if #(parameter int WIDTH = 4, parameter int MODULUS = 4);
  logic               stop;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic               up;
  logic [WIDTH-1:0]   count_o;
  logic               tick_o;
  logic               tc_o;
  logic [MODULUS-1:0] onehot_o;
  modport master (output stop, load, load_val, up, input count_o, tick_o, tc_o, onehot_o);
  modport slave  (input stop, load, load_val, up, output count_o, tick_o, tc_o, onehot_o);
endinterface

// File: rtl/module_scan_counter.sv
// module_scan_counter: prescaled modulo-N up/down scan counter with wrap or saturate,
// tick/terminal-count strobes and a one-hot decode for digit selection.
module module_scan_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 4,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic rst,
  module_scan_counter_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  logic [WIDTH-1:0] count, nxt;
  logic [PW-1:0] pre_cnt;
  logic tick, tc, step, at_end;
  always_comb begin
    step   = !bus.stop && pre_cnt == PLAST;
    at_end = bus.up ? count == LAST : count == '0;
    nxt    = at_end ? (SATURATE != 0 ? count : (bus.up ? '0 : LAST))
                    : (bus.up ? count + 1'b1 : count - 1'b1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      pre_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (bus.load) begin
      count   <= bus.load_val > LAST ? LAST : bus.load_val;
      pre_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else begin
      tick <= step;
      tc   <= step && at_end;
      if (!bus.stop) pre_cnt <= step ? '0 : pre_cnt + 1'b1;
      if (step) count <= nxt;
    end
  end
  for (genvar k = 0; k < MODULUS; k++) begin : g_dec
    assign bus.onehot_o[k] = count == WIDTH'(k);
  end
  assign bus.count_o = count;
  assign bus.tick_o  = tick;
  assign bus.tc_o    = tc;
endmodule

// File: tb/tb_module_scan_counter.sv
// tb_module_scan_counter: directed checks over four counter configurations
// (wrap mod-4, prescale-3 mod-10, wrap mod-10, saturate mod-10).
module tb_module_scan_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  module_scan_counter_if #(.WIDTH(4), .MODULUS(4))  ba();
  module_scan_counter_if #(.WIDTH(4), .MODULUS(10)) bb();
  module_scan_counter_if #(.WIDTH(4), .MODULUS(10)) bc();
  module_scan_counter_if #(.WIDTH(4), .MODULUS(10)) bd();
  module_scan_counter #(.WIDTH(4), .MODULUS(4),  .PRESCALE(1), .SATURATE(0)) ua (.clk(clk), .rst(rst), .bus(ba));
  module_scan_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) ub (.clk(clk), .rst(rst), .bus(bb));
  module_scan_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) uc (.clk(clk), .rst(rst), .bus(bc));
  module_scan_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) ud (.clk(clk), .rst(rst), .bus(bd));

  task automatic test_reset();
    ba.stop = 1; ba.load = 0; ba.up = 1; ba.load_val = 0;
    bb.stop = 1; bb.load = 0; bb.up = 1; bb.load_val = 0;
    bc.stop = 1; bc.load = 0; bc.up = 1; bc.load_val = 0;
    bd.stop = 1; bd.load = 0; bd.up = 1; bd.load_val = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ba.count_o !== 4'd0) begin errors++; $display("FAIL reset count got %0d want 0", ba.count_o); end
    checks++; if (ba.tick_o !== 1'b0) begin errors++; $display("FAIL reset tick got %b want 0", ba.tick_o); end
    checks++; if (ba.tc_o !== 1'b0) begin errors++; $display("FAIL reset tc got %b want 0", ba.tc_o); end
    checks++; if (ba.onehot_o !== 4'b0001) begin errors++; $display("FAIL reset onehot got %b want 0001", ba.onehot_o); end
    checks++; if (bd.onehot_o !== 10'b1) begin errors++; $display("FAIL reset onehot10 got %b want 1", bd.onehot_o); end
  endtask

  task automatic test_free_run();
    int ec [4] = '{1, 2, 3, 0};
    int et [4] = '{0, 0, 0, 1};
    rst = 1'b1; ba.stop = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ba.count_o !== 4'(ec[i])) begin errors++; $display("FAIL free_run count[%0d] got %0d want %0d", i, ba.count_o, ec[i]); end
      checks++; if (ba.onehot_o !== 4'(1 << ec[i])) begin errors++; $display("FAIL free_run onehot[%0d] got %b want %b", i, ba.onehot_o, 4'(1 << ec[i])); end
      checks++; if (ba.tick_o !== 1'b1) begin errors++; $display("FAIL free_run tick[%0d] got %b want 1", i, ba.tick_o); end
      checks++; if (ba.tc_o !== 1'(et[i])) begin errors++; $display("FAIL free_run tc[%0d] got %b want %0d", i, ba.tc_o, et[i]); end
    end
    ba.stop = 1;
    @(negedge clk);
    checks++; if (ba.count_o !== 4'd0 || ba.tick_o !== 1'b0 || ba.tc_o !== 1'b0)
      begin errors++; $display("FAIL free_run stopped got c=%0d t=%b tc=%b want 0/0/0", ba.count_o, ba.tick_o, ba.tc_o); end
  endtask

  task automatic test_prescale_stop();
    int st [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    int ec [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
    int et [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 12; i++) begin
      bb.stop = 1'(st[i]);
      @(negedge clk);
      checks++; if (bb.count_o !== 4'(ec[i])) begin errors++; $display("FAIL prescale count[%0d] got %0d want %0d", i, bb.count_o, ec[i]); end
      checks++; if (bb.tick_o !== 1'(et[i])) begin errors++; $display("FAIL prescale tick[%0d] got %b want %0d", i, bb.tick_o, et[i]); end
    end
    bb.stop = 1;
  endtask

  // rows: load, load_val, up, stop | count, tick, tc
  task automatic test_down_wrap();
    int v [5][7] = '{'{1, 1, 0, 1, 1, 0, 0}, '{0, 0, 0, 0, 0, 1, 0}, '{0, 0, 0, 0, 9, 1, 1},
                     '{0, 0, 1, 0, 0, 1, 1}, '{0, 0, 1, 1, 0, 0, 0}};
    for (int i = 0; i < 5; i++) begin
      bc.load = 1'(v[i][0]); bc.load_val = 4'(v[i][1]); bc.up = 1'(v[i][2]); bc.stop = 1'(v[i][3]);
      @(negedge clk);
      checks++; if (bc.count_o !== 4'(v[i][4])) begin errors++; $display("FAIL down_wrap count[%0d] got %0d want %0d", i, bc.count_o, v[i][4]); end
      checks++; if (bc.tick_o !== 1'(v[i][5])) begin errors++; $display("FAIL down_wrap tick[%0d] got %b want %0d", i, bc.tick_o, v[i][5]); end
      checks++; if (bc.tc_o !== 1'(v[i][6])) begin errors++; $display("FAIL down_wrap tc[%0d] got %b want %0d", i, bc.tc_o, v[i][6]); end
      checks++; if (bc.onehot_o !== 10'(1 << v[i][4])) begin errors++; $display("FAIL down_wrap onehot[%0d] got %b", i, bc.onehot_o); end
    end
    bc.load = 0;
  endtask

  task automatic test_saturate();
    int v [6][7] = '{'{1, 8, 1, 0, 8, 0, 0}, '{0, 0, 1, 0, 9, 1, 0}, '{0, 0, 1, 0, 9, 1, 1},
                     '{0, 0, 1, 0, 9, 1, 1}, '{0, 0, 0, 0, 8, 1, 0}, '{0, 0, 0, 1, 8, 0, 0}};
    for (int i = 0; i < 6; i++) begin
      bd.load = 1'(v[i][0]); bd.load_val = 4'(v[i][1]); bd.up = 1'(v[i][2]); bd.stop = 1'(v[i][3]);
      @(negedge clk);
      checks++; if (bd.count_o !== 4'(v[i][4])) begin errors++; $display("FAIL saturate count[%0d] got %0d want %0d", i, bd.count_o, v[i][4]); end
      checks++; if (bd.tick_o !== 1'(v[i][5])) begin errors++; $display("FAIL saturate tick[%0d] got %b want %0d", i, bd.tick_o, v[i][5]); end
      checks++; if (bd.tc_o !== 1'(v[i][6])) begin errors++; $display("FAIL saturate tc[%0d] got %b want %0d", i, bd.tc_o, v[i][6]); end
    end
    bd.load = 0;
  endtask

  task automatic test_load_clamp();
    int v [6][7] = '{'{1, 15, 1, 1, 9, 0, 0}, '{1, 10, 1, 1, 9, 0, 0}, '{1, 0, 1, 1, 0, 0, 0},
                     '{1, 5, 1, 0, 5, 0, 0}, '{0, 0, 1, 0, 6, 1, 0}, '{0, 0, 1, 1, 6, 0, 0}};
    for (int i = 0; i < 6; i++) begin
      bc.load = 1'(v[i][0]); bc.load_val = 4'(v[i][1]); bc.up = 1'(v[i][2]); bc.stop = 1'(v[i][3]);
      @(negedge clk);
      checks++; if (bc.count_o !== 4'(v[i][4])) begin errors++; $display("FAIL load_clamp count[%0d] got %0d want %0d", i, bc.count_o, v[i][4]); end
      checks++; if (bc.tick_o !== 1'(v[i][5])) begin errors++; $display("FAIL load_clamp tick[%0d] got %b want %0d", i, bc.tick_o, v[i][5]); end
      checks++; if (bc.tc_o !== 1'(v[i][6])) begin errors++; $display("FAIL load_clamp tc[%0d] got %b want %0d", i, bc.tc_o, v[i][6]); end
    end
    bc.load = 0;
  endtask

  task automatic test_async_reset();
    ba.stop = 0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ba.count_o !== 4'd2 || ba.tick_o !== 1'b1) begin errors++; $display("FAIL async_pre got c=%0d t=%b want 2/1", ba.count_o, ba.tick_o); end
    #2 rst = 1'b0;
    #1;
    checks++; if (ba.count_o !== 4'd0) begin errors++; $display("FAIL async count got %0d want 0", ba.count_o); end
    checks++; if (ba.onehot_o !== 4'b0001) begin errors++; $display("FAIL async onehot got %b want 0001", ba.onehot_o); end
    checks++; if (ba.tick_o !== 1'b0 || ba.tc_o !== 1'b0) begin errors++; $display("FAIL async strobes got t=%b tc=%b want 0/0", ba.tick_o, ba.tc_o); end
    ba.stop = 1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescale_stop();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
